// File: rtl/demux_pulse_counter.sv
// demux_pulse_counter
//   Counts rising edges on the four demux channel lines over a fixed window of
//   WINDOW clocks opened by a one-cycle start, then freezes the counts for
//   readout through a one-cycle-latency registered read port.
//
// Parameters
//   WIDTH   per-channel count width; counts saturate at 2^WIDTH-1
//   WINDOW  measurement window length in clocks (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   y0..y3       channel lines, synchronous to clk
//   start        one-cycle pulse: clear counts and open a window
//   rd_en        read request
//   rd_sel       channel to read (0 -> y0 .. 3 -> y3)
//   busy         window open
//   done         window completed, until next start or rst
//   rd_data      returned count
//   rd_valid     rd_data valid this cycle
//   ovf          per-channel saturation flags, bit i belongs to yi
module demux_pulse_counter #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             start,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [3:0]       ovf
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [3:0]       y_now;
  logic [3:0]       y_p0;
  logic [3:0]       rise;
  logic [WIN_W-1:0] win_cnt;
  logic [WIDTH-1:0] cnt [4];

  // A counter already at full scale stays there.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  assign y_now = {y3, y2, y1, y0};
  assign rise  = y_now & ~y_p0;
  assign busy  = (state == COUNT);
  assign done  = (state == DONE);

  // Next-state logic; accept marks a start that opens a new window.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COUNT;
          accept    = 1'b1;
        end
      end
      COUNT: begin
        // win_cnt holds the number of sample points already taken, so the
        // WINDOW-th sample closes the window.
        if (win_cnt == WIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt = COUNT;
          accept    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: previous-cycle sample of the channel lines, tracked in every state.
  always_ff @(posedge clk) begin
    if (rst) y_p0 <= '0;
    else     y_p0 <= y_now;
  end

  // Counting: a start clears everything and ignores same-cycle rises.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      win_cnt <= '0;
      ovf     <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (state == COUNT) begin
      win_cnt <= win_cnt + WIN_W'(1);
      for (int i = 0; i < 4; i++) begin
        if (rise[i]) begin
          if (&cnt[i]) ovf[i] <= 1'b1;
          cnt[i] <= sat_inc(cnt[i]);
        end
      end
    end
  end

  // Read port: samples the count as held before the edge, so a read issued
  // together with a clearing start returns the pre-clear value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= cnt[rd_sel];
    end
  end

endmodule
